fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl.sv | 94 +++++++++
 tb/tb_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register load strobe and a single-outstanding
// instruction-memory fetch port, and hands fetched words to decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  input  logic        trap_i,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;
  logic   flush;

  // Any trap or redirect outside BOOT discards the current fetch.
  assign flush = (state != BOOT) && (trap_i || redirect_i);

  assign imem_req    = (state == FETCH);
  assign imem_addr   = imem_req ? pc : 32'h0000_0000;
  assign instr_valid = (state == VALID);

  always_comb begin
    pc_en      = 1'b0;
    next_pc    = RESET_VECTOR;
    misalign_o = 1'b0;
    if (state == BOOT) begin
      // Reset is folded in so the strobe stays low while reset is held.
      pc_en = !reset;
    end else if (trap_i) begin
      pc_en   = 1'b1;
      next_pc = TRAP_VECTOR;
    end else if (redirect_i) begin
      pc_en = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        next_pc    = TRAP_VECTOR;
        misalign_o = 1'b1;
      end else begin
        next_pc = redirect_pc;
      end
    end else if (state == VALID && !stall_i) begin
      pc_en   = 1'b1;
      next_pc = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      instr <= 32'h0000_0000;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (flush) begin
            state <= imem_rvalid ? FETCH : DRAIN;
          end else if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= VALID;
          end
        end
        VALID: begin
          if (flush || !stall_i) state <= FETCH;
        end
        DRAIN: begin
          // A flush landing on the same cycle as the stale response still
          // retires that response, so there is nothing left to wait for.
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC register model, latency-programmable
// memory responder feeding an instruction scoreboard, vector table plus sequences.
module tb_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic        trap_i;
  logic        misalign_o;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
    .trap_i(trap_i), .misalign_o(misalign_o)
  );

  // External PC register; the junk reset value shows BOOT really loads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= 32'hDEAD_BEE0;
    else if (pc_en) pc <= next_pc;
  end

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int drops_req = 0;
  int drops_done = 0;
  logic [31:0] sb_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall_i = 1'b0;
    redirect_i = 1'b0;
    trap_i = 1'b0;
    redirect_pc = 32'h0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      idle();
      #1;
      if (instr_valid) break;
      n++;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL wait_valid: got instr_valid=0 required 1 within %0d cycles", budget);
        break;
      end
    end
  endtask

  // Memory responder and instruction monitor, both evaluated on the falling edge.
  initial begin
    int cnt;
    logic busy;
    logic prev_valid;
    logic [31:0] raddr;
    logic [31:0] e;
    busy = 1'b0;
    cnt = 0;
    raddr = 32'h0;
    prev_valid = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
        imem_rvalid = 1'b0;
        prev_valid = 1'b0;
        sb_q.delete();
        drops_done = drops_req;
      end else begin
        imem_rvalid = 1'b0;
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata = mem(raddr);
            if (drops_done < drops_req) drops_done++;
            else sb_q.push_back(mem(raddr));
          end
        end else if (imem_req) begin
          raddr = imem_addr;
          cnt = lat;
          busy = 1'b1;
        end
        if (instr_valid && !prev_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got %h required no instruction", instr);
          end else begin
            e = sb_q.pop_front();
            chk("instr", instr, e);
            $display("txn instr=%h expected=%h pc=%h", instr, e, pc);
          end
        end
        prev_valid = instr_valid;
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        redir;
    logic        trap;
    logic [31:0] rpc;
    logic        seq;
    logic        exp_en;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vt[9];

  initial begin
    // stall, redir, trap, rpc, seq, exp_en, exp_pc, exp_mis
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, TV,            1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b1, TV,            1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_2002, 1'b0, 1'b1, TV,            1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b1, 32'h0000_0400, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 32'h0000_2001, 1'b0, 1'b1, TV,            1'b0};
    vt[8] = '{1'b1, 1'b1, 1'b0, 32'h0000_2003, 1'b0, 1'b1, TV,            1'b1};

    reset = 1'b1;
    idle();
    lat = 1;

    // Reset state, with a misaligned redirect pending to prove it is ignored.
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc = 32'h0000_2002;
    @(negedge clk);
    #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_next_pc", next_pc, RV);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_misalign", misalign_o, 0);

    // BOOT cycle: load the reset vector, redirect still ignored.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot_pc_en", pc_en, 1);
    chk("boot_next_pc", next_pc, RV);
    chk("boot_misalign", misalign_o, 0);

    cyc(); #1;
    chk("fetch0_req", imem_req, 1);
    chk("fetch0_addr", imem_addr, 32'h0);
    cyc(); #1;
    chk("fetch0_req_held", imem_req, 1);
    cyc(); #1;
    chk("valid0", instr_valid, 1);
    chk("adv0_pc_en", pc_en, 1);
    chk("adv0_next_pc", next_pc, 32'h4);
    cyc(); #1;
    chk("fetch1_req", imem_req, 1);
    chk("fetch1_addr", imem_addr, 32'h4);

    // Stall hold in VALID for 3 cycles, then release.
    lat = 2;
    wait_valid(20);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      stall_i = 1'b1;
      #1;
      chk("stall_pc_en", pc_en, 0);
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr, mem(pc));
    end
    cyc(); #1;
    chk("unstall_pc_en", pc_en, 1);
    chk("unstall_next_pc", next_pc, pc + 32'd4);

    // Control vectors applied in VALID.
    for (int i = 0; i < 9; i++) begin
      lat = 1 + (i % 3);
      wait_valid(20);
      stall_i = vt[i].stall;
      redirect_i = vt[i].redir;
      trap_i = vt[i].trap;
      redirect_pc = vt[i].rpc;
      #1;
      chk($sformatf("vec%0d_pc_en", i), pc_en, vt[i].exp_en);
      if (vt[i].exp_en)
        chk($sformatf("vec%0d_next_pc", i), next_pc, vt[i].seq ? pc + 32'd4 : vt[i].exp_pc);
      chk($sformatf("vec%0d_misalign", i), misalign_o, vt[i].exp_mis);
      if (vt[i].exp_mis) begin
        cyc(); #1;
        chk($sformatf("vec%0d_misalign_end", i), misalign_o, 0);
      end
    end

    // Redirect with the fetch still outstanding: drain, discard, refetch.
    lat = 3;
    wait_valid(20);
    cyc();
    drops_req++;
    redirect_i = 1'b1;
    redirect_pc = 32'h0000_2000;
    #1;
    chk("drain_req_c0", imem_req, 1);
    chk("drain_pc_en", pc_en, 1);
    chk("drain_next_pc", next_pc, 32'h2000);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("drain_req_low", imem_req, 0);
      chk("drain_valid_low", instr_valid, 0);
    end
    cyc(); #1;
    chk("drain_refetch_req", imem_req, 1);
    chk("drain_refetch_addr", imem_addr, 32'h2000);

    // Redirect in the same cycle the response arrives.
    lat = 1;
    wait_valid(20);
    cyc();
    drops_req++;
    #1;
    chk("same_req", imem_req, 1);
    cyc();
    redirect_i = 1'b1;
    redirect_pc = 32'h0000_3000;
    #1;
    chk("same_pc_en", pc_en, 1);
    chk("same_next_pc", next_pc, 32'h3000);
    cyc(); #1;
    chk("same_refetch_req", imem_req, 1);
    chk("same_refetch_addr", imem_addr, 32'h3000);
    chk("same_valid_low", instr_valid, 0);

    // Wrap of pc+4 at the top of the address space.
    wait_valid(20);
    redirect_i = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap_redirect", next_pc, 32'hFFFF_FFFC);
    wait_valid(20);
    #1;
    chk("wrap_pc_en", pc_en, 1);
    chk("wrap_next_pc", next_pc, 32'h0);

    // Asynchronous reset in the middle of a FETCH cycle.
    cyc(); #1;
    chk("arst_pre_req", imem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc_en", pc_en, 0);
    chk("arst_addr", imem_addr, 0);
    cyc();
    cyc();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reboot_pc_en", pc_en, 1);
    chk("reboot_next_pc", next_pc, RV);
    wait_valid(20);
    cyc(); #1;
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
